// File: rtl/gen_seq_pkg.sv
// Shared types and constants for the generator sequencer: FSM state encoding
// and config-table field indices.
package gen_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_GUARD = 3'd3,
      S_WAIT  = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   localparam int NUM_FLDS = 7;

   localparam logic [2:0] FLD_ITER   = 3'd0;
   localparam logic [2:0] FLD_PERIOD = 3'd1;
   localparam logic [2:0] FLD_DUTY   = 3'd2;
   localparam logic [2:0] FLD_START  = 3'd3;
   localparam logic [2:0] FLD_SHIFT  = 3'd4;
   localparam logic [2:0] FLD_INCR   = 3'd5;
   localparam logic [2:0] FLD_DELAY  = 3'd6;

endpackage

// File: rtl/gen_seq_table.sv
// DEPTH x NUM_FLDS x 32 config register file: one field write port and one
// asynchronous whole-entry read port. Contents clear on reset.
module gen_seq_table
   import gen_seq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int IDX_W = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         we,
   input  logic [IDX_W-1:0]             widx,
   input  logic [2:0]                   wfld,
   input  logic [31:0]                  wdata,
   input  logic [IDX_W-1:0]             ridx,
   output logic [NUM_FLDS-1:0][31:0]    rdata
);

   logic [NUM_FLDS-1:0][31:0] mem [DEPTH];

   // Field code 7 matches no loop iteration, so it never writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int f = 0; f < NUM_FLDS; f++) begin
            if (wfld == 3'(f)) begin
               mem[widx][f] <= wdata;
            end
         end
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/gen_sequencer.sv
// Steps a Generator through a programmed list of config entries, one run per entry.
// Optional GEN_SEQ_REPEAT_EN adds repeat_i for repeat_i+1 passes over the list.
module gen_sequencer
   import gen_seq_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int IDX_W    = $clog2(DEPTH),
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we_i,
   input  logic [IDX_W-1:0]    cfg_idx_i,
   input  logic [2:0]          cfg_fld_i,
   input  logic [31:0]         cfg_data_i,
   input  logic                start_i,
   input  logic [IDX_W:0]      num_i,
   input  logic                abort_i,
   input  logic                gen_done_i,
`ifdef GEN_SEQ_REPEAT_EN
   input  logic [15:0]         repeat_i,
`endif
   output logic                gen_run_o,
   output logic [31:0]         gen_iter_o,
   output logic [PERIOD_W-1:0] gen_period_o,
   output logic [PERIOD_W-1:0] gen_duty_o,
   output logic [31:0]         gen_start_o,
   output logic [31:0]         gen_shift_o,
   output logic [31:0]         gen_incr_o,
   output logic [31:0]         gen_delay_o,
   output logic                busy_o,
   output logic [IDX_W-1:0]    idx_o,
   output logic                done_o,
   output state_t              state_o
);

   localparam logic [IDX_W:0] DEPTH_N = (IDX_W+1)'(DEPTH);

   state_t                    state, nxt;
   logic [IDX_W-1:0]          idx;
   logic [IDX_W:0]            num;
   logic [NUM_FLDS-1:0][31:0] rdata;
   logic                      load_en, idx_clr, idx_inc, latch, last;
   logic                      run_c, done_c;
`ifdef GEN_SEQ_REPEAT_EN
   logic [15:0]               rep_cnt, rep_max;
   logic                      rep_inc;
`endif

   gen_seq_table #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_table (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (cfg_we_i && (state == S_IDLE)),
      .widx  (cfg_idx_i),
      .wfld  (cfg_fld_i),
      .wdata (cfg_data_i),
      .ridx  (idx),
      .rdata (rdata)
   );

   assign last = ({1'b0, idx} == (num - 1'b1));

   always_comb begin
      nxt     = state;
      load_en = 1'b0;
      idx_clr = 1'b0;
      idx_inc = 1'b0;
      latch   = 1'b0;
      run_c   = 1'b0;
      done_c  = 1'b0;
`ifdef GEN_SEQ_REPEAT_EN
      rep_inc = 1'b0;
`endif
      case (state)
         S_IDLE: if (start_i) begin
            latch   = 1'b1;
            idx_clr = 1'b1;
            nxt     = (num_i == '0) ? S_FIN : S_LOAD;
         end
         S_LOAD: begin
            load_en = 1'b1;
            nxt     = S_RUN;
         end
         S_RUN: begin
            run_c = 1'b1;
            nxt   = S_GUARD;
         end
         // A done level left over from the previous run must not end this one.
         S_GUARD: nxt = S_WAIT;
         S_WAIT: if (gen_done_i) begin
            if (last) begin
`ifdef GEN_SEQ_REPEAT_EN
               if (rep_cnt < rep_max) begin
                  rep_inc = 1'b1;
                  idx_clr = 1'b1;
                  nxt     = S_LOAD;
               end else begin
                  nxt = S_FIN;
               end
`else
               nxt = S_FIN;
`endif
            end else begin
               idx_inc = 1'b1;
               nxt     = S_LOAD;
            end
         end
         S_FIN: begin
            done_c = 1'b1;
            nxt    = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
      if (abort_i && (state != S_IDLE)) begin
         nxt     = S_IDLE;
         load_en = 1'b0;
         idx_clr = 1'b0;
         idx_inc = 1'b0;
         run_c   = 1'b0;
         done_c  = 1'b0;
`ifdef GEN_SEQ_REPEAT_EN
         rep_inc = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         idx          <= '0;
         num          <= '0;
         gen_iter_o   <= '0;
         gen_period_o <= '0;
         gen_duty_o   <= '0;
         gen_start_o  <= '0;
         gen_shift_o  <= '0;
         gen_incr_o   <= '0;
         gen_delay_o  <= '0;
      end else begin
         state <= nxt;
         if (latch) num <= (num_i > DEPTH_N) ? DEPTH_N : num_i;
         if (idx_clr)      idx <= '0;
         else if (idx_inc) idx <= idx + 1'b1;
         if (load_en) begin
            gen_iter_o   <= rdata[FLD_ITER];
            gen_period_o <= rdata[FLD_PERIOD][PERIOD_W-1:0];
            gen_duty_o   <= rdata[FLD_DUTY][PERIOD_W-1:0];
            gen_start_o  <= rdata[FLD_START];
            gen_shift_o  <= rdata[FLD_SHIFT];
            gen_incr_o   <= rdata[FLD_INCR];
            gen_delay_o  <= rdata[FLD_DELAY];
         end
      end
   end

`ifdef GEN_SEQ_REPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt <= '0;
         rep_max <= '0;
      end else if (latch) begin
         rep_cnt <= '0;
         rep_max <= repeat_i;
      end else if (rep_inc) begin
         rep_cnt <= rep_cnt + 16'd1;
      end
   end
`endif

   assign gen_run_o = run_c;
   assign done_o    = done_c;
   assign busy_o    = (state != S_IDLE);
   assign idx_o     = idx;
   assign state_o   = state;

endmodule

// File: tb/tb_gen_sequencer.sv
// Directed bench for gen_sequencer: a Generator done model plus a run monitor
// feeding a scoreboard of expected gen_start_o / idx_o per run.
module tb_gen_sequencer;
   import gen_seq_pkg::*;

   localparam int DEPTH    = 8;
   localparam int IDX_W    = 3;
   localparam int PERIOD_W = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                cfg_we_i = 1'b0;
   logic [IDX_W-1:0]    cfg_idx_i = '0;
   logic [2:0]          cfg_fld_i = '0;
   logic [31:0]         cfg_data_i = '0;
   logic                start_i = 1'b0;
   logic [IDX_W:0]      num_i = '0;
   logic                abort_i = 1'b0;
   logic                gen_done_i = 1'b0;
`ifdef GEN_SEQ_REPEAT_EN
   logic [15:0]         repeat_i = '0;
`endif
   logic                gen_run_o, busy_o, done_o;
   logic [31:0]         gen_iter_o, gen_start_o, gen_shift_o, gen_incr_o, gen_delay_o;
   logic [PERIOD_W-1:0] gen_period_o, gen_duty_o;
   logic [IDX_W-1:0]    idx_o;
   state_t              state_o;

   gen_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PERIOD_W(PERIOD_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_fld_i(cfg_fld_i), .cfg_data_i(cfg_data_i),
      .start_i(start_i), .num_i(num_i), .abort_i(abort_i), .gen_done_i(gen_done_i),
`ifdef GEN_SEQ_REPEAT_EN
      .repeat_i(repeat_i),
`endif
      .gen_run_o(gen_run_o), .gen_iter_o(gen_iter_o), .gen_period_o(gen_period_o),
      .gen_duty_o(gen_duty_o), .gen_start_o(gen_start_o), .gen_shift_o(gen_shift_o),
      .gen_incr_o(gen_incr_o), .gen_delay_o(gen_delay_o), .busy_o(busy_o),
      .idx_o(idx_o), .done_o(done_o), .state_o(state_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int ncyc = 0;
   always @(posedge clk) ncyc++;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_err    = 0;
   logic [31:0]      exp_q[$];
   logic [IDX_W-1:0] exp_idx_q[$];
   int run_cyc_q[$];
   int run_cnt  = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int t0 = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Generator model (done 5 cycles after each run) and run/done monitor.
   logic hold_done = 1'b0;
   logic prev_run  = 1'b0;
   int   dly       = 0;
   always @(negedge clk) begin
      if (hold_done) begin
         gen_done_i = 1'b1;
      end else if (gen_run_o) begin
         gen_done_i = 1'b0;
         dly = 5;
      end else if (dly > 0) begin
         dly--;
         if (dly == 0) gen_done_i = 1'b1;
      end
      if (gen_run_o) begin
         check("run_single_cycle", {31'b0, prev_run}, 32'd0);
         check("run_expected", {31'b0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            check("run_start", gen_start_o, exp_q.pop_front());
            check("run_idx", {29'b0, idx_o}, {29'b0, exp_idx_q.pop_front()});
         end
         run_cnt++;
         run_cyc_q.push_back(ncyc);
      end
      if (done_o) begin
         done_cnt++;
         done_cyc = ncyc;
      end
      prev_run = gen_run_o;
   end

   // ---------------- driver tasks ----------------
   task automatic write_cfg(input logic [IDX_W-1:0] i, input logic [2:0] f, input logic [31:0] d);
      cfg_we_i = 1'b1; cfg_idx_i = i; cfg_fld_i = f; cfg_data_i = d;
      @(negedge clk);
      cfg_we_i = 1'b0;
   endtask

   task automatic start_seq(input logic [IDX_W:0] n);
      start_i = 1'b1; num_i = n; t0 = ncyc;
      run_cyc_q.delete();
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic expect_run(input logic [31:0] s, input logic [IDX_W-1:0] i);
      exp_q.push_back(s);
      exp_idx_q.push_back(i);
   endtask

   task automatic wait_idle(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (!busy_o) break;
         @(negedge clk);
      end
      check("idle_within_budget", {31'b0, busy_o}, 32'd0);
   endtask

   task automatic wait_wait_idx(input logic [IDX_W-1:0] i);
      for (int k = 0; k < 100; k++) begin
         if (state_o == S_WAIT && idx_o == i) break;
         @(negedge clk);
      end
      check("reach_wait", {29'b0, idx_o, state_o == S_WAIT}, {29'b0, i, 1'b1});
   endtask

   int runs0, dones0;

   // ---------------- main sequence ----------------
   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_run", {31'b0, gen_run_o}, 32'd0);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_idx", {29'b0, idx_o}, 32'd0);
      check("rst_start", gen_start_o, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 3-entry run; last write lands the cycle before start_i
      write_cfg(3'd0, FLD_START, 32'h10);
      write_cfg(3'd1, FLD_START, 32'h20);
      write_cfg(3'd1, FLD_ITER, 32'd7);
      write_cfg(3'd2, FLD_PERIOD, 32'h0001_2345);
      write_cfg(3'd2, FLD_ITER, 32'd9);
      write_cfg(3'd2, FLD_START, 32'h30);
      expect_run(32'h10, 3'd0); expect_run(32'h20, 3'd1); expect_run(32'h30, 3'd2);
      runs0 = run_cnt; dones0 = done_cnt;
      start_seq(4'd3);
      wait_idle(200);
      check("seq3_runs", run_cnt - runs0, 3);
      check("seq3_dones", done_cnt - dones0, 1);
      check("seq3_first_run_lat", run_cyc_q[0] - t0, 2);
      check("seq3_run_gap", run_cyc_q[1] - run_cyc_q[0], 7);
      check("seq3_done_cyc", done_cyc - t0, 22);
      check("hold_start", gen_start_o, 32'h30);
      check("hold_iter", gen_iter_o, 32'd9);
      check("hold_period_trunc", {16'b0, gen_period_o}, 32'h2345);

      // Stale done held high from before start_i
      hold_done = 1'b1;
      @(negedge clk);
      expect_run(32'h10, 3'd0); expect_run(32'h20, 3'd1);
      runs0 = run_cnt; dones0 = done_cnt;
      start_seq(4'd2);
      wait_idle(100);
      hold_done = 1'b0;
      check("stale_runs", run_cnt - runs0, 2);
      check("stale_run_gap", run_cyc_q[1] - run_cyc_q[0], 4);
      check("stale_done_cyc", done_cyc - t0, 9);
      check("stale_dones", done_cnt - dones0, 1);

      // num_i = 0: done_o the cycle after start_i is sampled, no run
      runs0 = run_cnt; dones0 = done_cnt;
      start_seq(4'd0);
      check("zero_done_pulse", {31'b0, done_o}, 32'd1);
      check("zero_busy_fin", {31'b0, busy_o}, 32'd1);
      repeat (3) @(negedge clk);
      check("zero_runs", run_cnt - runs0, 0);
      check("zero_dones", done_cnt - dones0, 1);
      check("zero_done_cyc", done_cyc - t0, 1);

      // num_i = DEPTH+3 saturates to DEPTH
      expect_run(32'h10, 3'd0); expect_run(32'h20, 3'd1); expect_run(32'h30, 3'd2);
      for (int i = 3; i < DEPTH; i++) expect_run(32'h0, 3'(i));
      runs0 = run_cnt; dones0 = done_cnt;
      start_seq(4'(DEPTH + 3));
      wait_idle(300);
      check("sat_runs", run_cnt - runs0, DEPTH);
      check("sat_dones", done_cnt - dones0, 1);
      check("sat_done_cyc", done_cyc - t0, 57);

      // Abort in WAIT of entry 1, with writes attempted while busy
      expect_run(32'h10, 3'd0); expect_run(32'h20, 3'd1);
      runs0 = run_cnt; dones0 = done_cnt;
      start_seq(4'd3);
      write_cfg(3'd1, FLD_START, 32'hBAD);
      write_cfg(3'd0, FLD_START, 32'hDEAD);
      wait_wait_idx(3'd1);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("abort_busy", {31'b0, busy_o}, 32'd0);
      check("abort_state", {29'b0, state_o}, {29'b0, S_IDLE});
      repeat (10) @(negedge clk);
      check("abort_runs", run_cnt - runs0, 2);
      check("abort_no_done", done_cnt - dones0, 0);
      expect_run(32'h10, 3'd0); expect_run(32'h20, 3'd1);
      runs0 = run_cnt;
      start_seq(4'd2);
      wait_idle(100);
      check("readback_runs", run_cnt - runs0, 2);

      // Abort during RUN suppresses the run pulse
      runs0 = run_cnt; dones0 = done_cnt;
      start_seq(4'd1);
      @(posedge clk);
      #1 abort_i = 1'b1;
      #1 check("abort_run_state", {29'b0, state_o}, {29'b0, S_RUN});
      check("abort_run_forced0", {31'b0, gen_run_o}, 32'd0);
      @(posedge clk);
      #1 abort_i = 1'b0;
      check("abort_run_idle", {31'b0, busy_o}, 32'd0);
      @(negedge clk);
      repeat (3) @(negedge clk);
      check("abort_run_noruns", run_cnt - runs0, 0);
      check("abort_run_nodone", done_cnt - dones0, 0);

      // Async reset mid-WAIT of entry 1
      expect_run(32'h10, 3'd0); expect_run(32'h20, 3'd1);
      start_seq(4'd3);
      wait_wait_idx(3'd1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'b0, busy_o}, 32'd0);
      check("arst_run", {31'b0, gen_run_o}, 32'd0);
      check("arst_done", {31'b0, done_o}, 32'd0);
      check("arst_idx", {29'b0, idx_o}, 32'd0);
      check("arst_start", gen_start_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_scoreboard_empty", exp_q.size(), 0);
      expect_run(32'h0, 3'd0);
      runs0 = run_cnt;
      start_seq(4'd1);
      wait_idle(100);
      check("arst_table_cleared_runs", run_cnt - runs0, 1);

`ifdef GEN_SEQ_REPEAT_EN
      write_cfg(3'd0, FLD_START, 32'h10);
      write_cfg(3'd1, FLD_START, 32'h20);
      for (int p = 0; p < 3; p++) begin
         expect_run(32'h10, 3'd0);
         expect_run(32'h20, 3'd1);
      end
      repeat_i = 16'd2;
      runs0 = run_cnt; dones0 = done_cnt;
      start_seq(4'd2);
      repeat_i = 16'd0;
      wait_idle(300);
      check("rep_runs", run_cnt - runs0, 6);
      check("rep_dones", done_cnt - dones0, 1);
`endif

      repeat (2) @(negedge clk);
      check("final_scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
